// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - Avalon-MM burst arbiter between camera write and display read paths
// Optional: define FB_ARB_RD_PRIO_EN for strict read priority instead of round-robin.
module fb_mem_arbiter #(
  parameter int          ADDR_W      = 26,
  parameter int          BURST_LEN   = 16,
  parameter int          FRAME_WORDS = 307200,
  parameter int unsigned FB0_BASE    = 0,
  parameter int unsigned FB1_BASE    = 'h80000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [9:0]        cam_words,
  input  logic [9:0]        adv_free,
  input  logic              avl_ready,
  input  logic              avl_rdata_valid,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [6:0]        avl_burstcount,
  output logic              avl_write,
  output logic              avl_read,
  output logic              cam_rdreq,
  output logic              adv_wrreq,
  output logic              wr_fb,
  output logic              rd_fb,
  output logic              frame_wr_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR      = 2'd1;
  localparam logic [1:0] S_RD_CMD  = 2'd2;
  localparam logic [1:0] S_RD_DATA = 2'd3;

  localparam logic [ADDR_W-1:0] BL_A    = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] FB0_A   = ADDR_W'(FB0_BASE);
  localparam logic [ADDR_W-1:0] FB1_A   = ADDR_W'(FB1_BASE);
  localparam logic [9:0]        BL_10   = 10'(BURST_LEN);
  localparam logic [6:0]        LAST_BEAT = 7'(BURST_LEN - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [6:0]        beat_cnt;
  logic              last_grant_wr, last_done, last_done_nxt;
  logic              wr_elig, rd_elig, grant_wr, grant_rd;
  logic              wr_last_beat, rd_last_beat, wr_frame_end, rd_frame_end;

  assign avl_burstcount = 7'(BURST_LEN);
  assign cam_rdreq      = avl_write & avl_ready;
  assign adv_wrreq      = (state == S_RD_DATA) & avl_rdata_valid;
  assign wr_last_beat   = cam_rdreq && (beat_cnt == LAST_BEAT);
  assign rd_last_beat   = adv_wrreq && (beat_cnt == LAST_BEAT);
  assign wr_ptr_nxt     = wr_ptr + BL_A;
  assign rd_ptr_nxt     = rd_ptr + BL_A;
  assign wr_frame_end   = wr_last_beat && (wr_ptr_nxt == FRAME_A);
  assign rd_frame_end   = rd_last_beat && (rd_ptr_nxt == FRAME_A);
  // A write frame ending in the same cycle hands its buffer straight to the reader.
  assign last_done_nxt  = wr_frame_end ? wr_fb : last_done;

  always_comb begin
    wr_elig = en && (state == S_IDLE) && (cam_words >= BL_10);
    rd_elig = en && (state == S_IDLE) && (adv_free >= BL_10);
`ifdef FB_ARB_RD_PRIO_EN
    grant_rd = rd_elig;
    grant_wr = wr_elig && !rd_elig;
`else
    grant_wr = wr_elig && (!rd_elig || !last_grant_wr);
    grant_rd = rd_elig && (!wr_elig || last_grant_wr);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      beat_cnt      <= '0;
      wr_fb         <= 1'b0;
      rd_fb         <= 1'b1;
      last_done     <= 1'b1;
      last_grant_wr <= 1'b0;
      avl_write     <= 1'b0;
      avl_read      <= 1'b0;
      avl_addr      <= '0;
      frame_wr_done <= 1'b0;
    end else begin
      frame_wr_done <= 1'b0;
      case (state)
        S_IDLE: begin
          beat_cnt <= '0;
          if (grant_wr) begin
            state         <= S_WR;
            avl_write     <= 1'b1;
            avl_addr      <= (wr_fb ? FB1_A : FB0_A) + wr_ptr;
            last_grant_wr <= 1'b1;
          end else if (grant_rd) begin
            state         <= S_RD_CMD;
            avl_read      <= 1'b1;
            avl_addr      <= (rd_fb ? FB1_A : FB0_A) + rd_ptr;
            last_grant_wr <= 1'b0;
          end
        end
        S_WR: begin
          if (cam_rdreq) begin
            beat_cnt <= beat_cnt + 7'd1;
            if (wr_last_beat) begin
              avl_write <= 1'b0;
              state     <= S_IDLE;
              if (wr_frame_end) begin
                wr_ptr        <= '0;
                frame_wr_done <= 1'b1;
                last_done     <= wr_fb;
                // Never move onto the buffer the display is scanning; drop the frame instead.
                if (~wr_fb != rd_fb) wr_fb <= ~wr_fb;
              end else begin
                wr_ptr <= wr_ptr_nxt;
              end
            end
          end
        end
        S_RD_CMD: begin
          if (avl_ready) begin
            avl_read <= 1'b0;
            state    <= S_RD_DATA;
          end
        end
        default: begin
          if (adv_wrreq) begin
            beat_cnt <= beat_cnt + 7'd1;
            if (rd_last_beat) begin
              state <= S_IDLE;
              if (rd_frame_end) begin
                rd_ptr <= '0;
                rd_fb  <= last_done_nxt;
              end else begin
                rd_ptr <= rd_ptr_nxt;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb/tb_fb_mem_arbiter.sv - randomized self-checking bench for fb_mem_arbiter
module tb_fb_mem_arbiter;

  localparam int BL = 16;
  localparam int FW = 32;
  localparam int B0 = 0;
  localparam int B1 = 'h80000;

  logic        clk = 1'b0;
  logic        reset, en, avl_ready, avl_rdata_valid;
  logic [9:0]  cam_words, adv_free;
  logic [25:0] avl_addr;
  logic [6:0]  avl_burstcount;
  logic        avl_write, avl_read, cam_rdreq, adv_wrreq, wr_fb, rd_fb, frame_wr_done;

  int n_checks = 0;
  int n_fail = 0;

  int m_wr_ptr, m_rd_ptr;
  bit m_wr_fb, m_rd_fb, m_last_done, m_last_wr, m_done_exp, abort;

  always #5 clk = ~clk;

  fb_mem_arbiter #(.ADDR_W(26), .BURST_LEN(BL), .FRAME_WORDS(FW), .FB0_BASE(B0), .FB1_BASE(B1)) dut (
    .clk(clk), .reset(reset), .en(en), .cam_words(cam_words), .adv_free(adv_free),
    .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid), .avl_addr(avl_addr),
    .avl_burstcount(avl_burstcount), .avl_write(avl_write), .avl_read(avl_read),
    .cam_rdreq(cam_rdreq), .adv_wrreq(adv_wrreq), .wr_fb(wr_fb), .rd_fb(rd_fb),
    .frame_wr_done(frame_wr_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // 0 = no grant, 1 = write, 2 = read
  function automatic int exp_grant(input bit e, input int cam, input int free);
    bit we, re;
    we = cam >= BL;
    re = free >= BL;
    if (!e || (!we && !re)) return 0;
`ifdef FB_ARB_RD_PRIO_EN
    return re ? 2 : 1;
`else
    if (we && re) return m_last_wr ? 2 : 1;
    return we ? 1 : 2;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
    avl_ready = 1'($urandom_range(0, 1));
    en = 1'($urandom_range(0, 1));
  endtask

  task automatic do_write();
    int addr, acc, cyc;
    addr = (m_wr_fb ? B1 : B0) + m_wr_ptr;
    acc = 0;
    cyc = 0;
    m_last_wr = 1;
    while (1) begin
      check("wr_cmd", avl_write, 1);
      check("wr_addr", avl_addr, addr);
      check("wr_no_read", avl_read, 0);
      check("cam_rdreq", cam_rdreq, avl_ready);
      if (avl_ready) acc++;
      if (acc == BL) break;
      if (++cyc > 500) begin
        check("wr_timeout", acc, BL);
        abort = 1;
        break;
      end
      next_cycle();
      @(negedge clk);
    end
    m_wr_ptr += BL;
    if (m_wr_ptr == FW) begin
      m_wr_ptr = 0;
      m_done_exp = 1;
      m_last_done = m_wr_fb;
      if ((m_wr_fb ^ 1'b1) != m_rd_fb) m_wr_fb = !m_wr_fb;
    end
  endtask

  task automatic do_read();
    int addr, beats, cyc, delay;
    addr = (m_rd_fb ? B1 : B0) + m_rd_ptr;
    m_last_wr = 0;
    cyc = 0;
    while (1) begin
      check("rd_cmd", avl_read, 1);
      check("rd_addr", avl_addr, addr);
      check("rd_no_write", avl_write, 0);
      if (avl_ready) break;
      if (++cyc > 500) begin
        check("rd_cmd_timeout", avl_read, 0);
        abort = 1;
        return;
      end
      next_cycle();
      @(negedge clk);
    end
    delay = $urandom_range(0, 5);
    beats = 0;
    cyc = 0;
    while (beats < BL) begin
      next_cycle();
      avl_rdata_valid = (delay == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
      if (delay > 0) delay--;
      @(negedge clk);
      check("rd_single_cmd", avl_read, 0);
      check("adv_wrreq", adv_wrreq, avl_rdata_valid);
      if (avl_rdata_valid) beats++;
      if (++cyc > 500) begin
        check("rd_data_timeout", beats, BL);
        abort = 1;
        return;
      end
    end
    m_rd_ptr += BL;
    if (m_rd_ptr == FW) begin
      m_rd_ptr = 0;
      m_rd_fb = m_last_done;
    end
  endtask

  initial begin
    int g;
    reset = 1'b0;
    en = 1'b1;
    cam_words = 10'd100;
    adv_free = 10'd100;
    avl_ready = 1'b1;
    avl_rdata_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_avl_write", avl_write, 0);
    check("rst_avl_read", avl_read, 0);
    check("rst_cam_rdreq", cam_rdreq, 0);
    check("rst_adv_wrreq", adv_wrreq, 0);
    check("rst_frame_done", frame_wr_done, 0);
    check("rst_avl_addr", avl_addr, 0);
    check("rst_wr_fb", wr_fb, 0);
    check("rst_rd_fb", rd_fb, 1);
    check("burstcount", avl_burstcount, BL);
    en = 1'b0;
    reset = 1'b1;
    m_wr_ptr = 0; m_rd_ptr = 0; m_wr_fb = 0; m_rd_fb = 1; m_last_done = 1;
    m_last_wr = 0; m_done_exp = 0; abort = 0;

    for (int it = 0; it < 120 && !abort; it++) begin
      @(posedge clk);
      #2;
      if (it == 0) begin
        en = 1'b1; cam_words = 10'd100; adv_free = 10'd100;
      end else begin
        en = ($urandom_range(0, 5) != 0);
        cam_words = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(16, 1023)) : 10'($urandom_range(0, 15));
        adv_free  = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(16, 1023)) : 10'($urandom_range(0, 15));
      end
      avl_ready = 1'($urandom_range(0, 1));
      avl_rdata_valid = 1'b0;
      g = exp_grant(en, int'(cam_words), int'(adv_free));
      @(negedge clk);
      check("idle_write", avl_write, 0);
      check("idle_read", avl_read, 0);
      check("idle_rdreq", cam_rdreq, 0);
      check("frame_wr_done", frame_wr_done, m_done_exp);
      check("wr_fb", wr_fb, m_wr_fb);
      check("rd_fb", rd_fb, m_rd_fb);
      m_done_exp = 0;
      @(posedge clk);
      #2;
      avl_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (g == 0) begin
        check("no_grant_write", avl_write, 0);
        check("no_grant_read", avl_read, 0);
      end else if (g == 1) begin
        do_write();
      end else begin
        do_read();
      end
    end

    if (!abort) begin
      @(posedge clk);
      #2;
      en = 1'b1; cam_words = 10'd100; adv_free = 10'd0; avl_ready = 1'b0; avl_rdata_valid = 1'b0;
      @(posedge clk);
      #2;
      @(negedge clk);
      check("mid_wr_cmd", avl_write, 1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #2;
      @(negedge clk);
      check("mid_rst_write", avl_write, 0);
      check("mid_rst_addr", avl_addr, 0);
      check("mid_rst_wr_fb", wr_fb, 0);
      check("mid_rst_rd_fb", rd_fb, 1);
      reset = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_mem_arbiter.md
# fb_mem_arbiter

Schedules the single Avalon-MM burst port of one frame-buffer memory between two requesters: the camera write path (drains the camera FIFO into memory) and the display read path (fills the ADV FIFO from memory). It also owns the ping-pong frame-buffer selection and the per-frame address counters. It sits between the camera/ADV FIFOs and the memory controller, downstream of the top-level control FSM, which gates it with `en`.

## Interface
Parameters:
- `ADDR_W`, 26: Avalon word-address width.
- `BURST_LEN`, 16: beats per burst; must be a power of two, ≤ 64.
- `FRAME_WORDS`, 307200: words per frame; must be a multiple of `BURST_LEN`.
- `FB0_BASE`, 0: word base address of buffer 0.
- `FB1_BASE`, 'h80000: word base address of buffer 1.

Ports:
- `clk` in 1: memory-side clock.
- `reset` in 1: synchronous, active-low.
- `en` in 1: streaming enable from the control FSM.
- `cam_words` in 10: occupancy of the camera FIFO. The FIFO is show-ahead.
- `adv_free` in 10: free entries in the ADV FIFO.
- `avl_ready` in 1: Avalon waitrequest_n.
- `avl_rdata_valid` in 1: Avalon read-data valid.
- `avl_addr` out `ADDR_W`: burst start address.
- `avl_burstcount` out 7: constant `BURST_LEN`.
- `avl_write` out 1: write beat valid.
- `avl_read` out 1: read command valid.
- `cam_rdreq` out 1: pop the camera FIFO.
- `adv_wrreq` out 1: push to the ADV FIFO.
- `wr_fb` out 1: buffer currently being written.
- `rd_fb` out 1: buffer currently being read.
- `frame_wr_done` out 1: one-cycle pulse when a written frame completes.

## Operation
- **States:** `S_IDLE`, `S_WR`, `S_RD_CMD`, `S_RD_DATA`.
- **Eligibility:**
  - Write is eligible when `cam_words >= BURST_LEN`.
  - Read is eligible when `adv_free >= BURST_LEN`.
  - Both are evaluated only in `S_IDLE`, and only while `en` = 1.
- **Arbitration:** round-robin. The requester granted last loses a tie; `last_grant` resets to read.
- **Write burst:**
  - Entering `S_WR` drives `avl_addr = base(wr_fb) + wr_ptr`.
  - `avl_write` is held until `BURST_LEN` beats are accepted. A beat is accepted when `avl_write & avl_ready`.
  - `cam_rdreq` equals beat acceptance.
  - After the last beat: `wr_ptr += BURST_LEN`, then return to `S_IDLE`.
- **Read burst:**
  - `S_RD_CMD` holds `avl_read` with `avl_addr = base(rd_fb) + rd_ptr` until `avl_ready`, then moves to `S_RD_DATA`.
  - In `S_RD_DATA`, `adv_wrreq = avl_rdata_valid`; count `BURST_LEN` valid beats.
  - Then `rd_ptr += BURST_LEN` and return to `S_IDLE`.
  - Exactly one read burst is ever outstanding.
- **Write frame end** (`wr_ptr` reaches `FRAME_WORDS`):
  - `wr_ptr` returns to 0, `frame_wr_done` pulses, and `last_done <= wr_fb`.
  - `wr_fb` toggles only if `~wr_fb != rd_fb`. Otherwise the same buffer is rewritten (frame dropped).
- **Read frame end:** `rd_ptr` returns to 0 and `rd_fb <= last_done`. If no frame has completed yet, the current buffer is re-read.
- **`en` deasserted mid-burst:** the current burst completes and no new grant is issued. Avalon bursts are never truncated.
- **Reset mid-burst:** all state is cleared immediately; memory-side recovery belongs to the controller reset.

## Timing
- **Reset values:**
  - State `S_IDLE`; `wr_ptr = rd_ptr = 0`.
  - `wr_fb` = 0, `rd_fb` = 1, `last_done` = 1.
  - `avl_write`, `avl_read`, `cam_rdreq`, `adv_wrreq`, `frame_wr_done` = 0; `avl_addr` = 0.
- **Latency:** grant decision in `S_IDLE` → `avl_write`/`avl_read` asserted on the next cycle. All Avalon outputs are registered.
- **Burst throughput:** a write burst occupies exactly `BURST_LEN` cycles with `avl_ready` held high.
- **Idle gap:** 1 cycle in `S_IDLE` between consecutive bursts.
- **Address stability:** `avl_addr` and `avl_burstcount` stay stable from command assertion until the first beat or the read command is accepted.
- **Combinational outputs:** `cam_rdreq` and `adv_wrreq` are combinational from `avl_ready`/`avl_rdata_valid` and state, so no FIFO word is lost or duplicated.
- **Simultaneous frame ends:** when the write and read frame ends fall in the same cycle, the write-end update of `last_done` is applied first. The reader therefore picks up the just-finished frame.
- **Buffer-switch timing:** `wr_fb`/`rd_fb` change only on the cycle after the final beat of a frame.

## Configuration
- **`FB_ARB_RD_PRIO_EN` defined:** read has strict priority whenever it is eligible, to protect HDMI underflow. Write is granted only when read is ineligible.
- **`FB_ARB_RD_PRIO_EN` undefined:** round-robin as described in Operation.

## Test plan
- **Reset values:** `reset`=0 for 2 cycles, `en`=1 → all outputs at reset values. First grant goes to write when both requesters are eligible, since `last_grant`=read.
- **Single write burst:** `cam_words`=16, `adv_free`=0, `avl_ready`=1 → 16 cycles of `avl_write`/`cam_rdreq`, `avl_addr`=0, then `wr_ptr`=16.
- **Backpressure:** `avl_ready` toggling 1/0 during a write → exactly 16 `cam_rdreq` pulses, and `avl_addr` stable throughout.
- **Read burst:** `adv_free`=512, `avl_rdata_valid` arriving 5 cycles after acceptance → 16 `adv_wrreq` pulses, `avl_addr`=`FB1_BASE`, no second `avl_read` before the 16th beat.
- **Frame swap and drop:** `FRAME_WORDS`=32, write 2 bursts → `frame_wr_done` pulse, `wr_fb`: 0→1 only while `rd_fb`=0. With `rd_fb`=1, `wr_fb` stays 0.
- **Priority:** both requesters eligible continuously → alternating grants W, R, W, R without the macro; R, R, R with `FB_ARB_RD_PRIO_EN`.
